// File: rtl/ps2_direction_encoder_pkg.sv
// Shared scancode constants, direction codes and parser state type for the
// PS/2 direction encoder.
package ps2_direction_encoder_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_P     = 8'h4D;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } parse_state_t;

    // Key index within a player: 0 up, 1 right, 2 down, 3 left.
    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_hit_t;

    function automatic key_hit_t lookup_p0(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 2'd0;
        case (code)
            KEY_W:   r.idx = 2'd0;
            KEY_D:   r.idx = 2'd1;
            KEY_S:   r.idx = 2'd2;
            KEY_A:   r.idx = 2'd3;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

    function automatic key_hit_t lookup_p1(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 2'd0;
        case (code)
            KEY_UP:    r.idx = 2'd0;
            KEY_RIGHT: r.idx = 2'd1;
            KEY_DOWN:  r.idx = 2'd2;
            KEY_LEFT:  r.idx = 2'd3;
            default:   r.hit = 1'b0;
        endcase
        return r;
    endfunction

    // Last-pressed wins while still held, else fixed priority up>right>down>left.
    function automatic logic [2:0] resolve_dir(input logic [3:0] held, input logic [1:0] last);
        if (held[last])  return {1'b0, last} + 3'd1;
        else if (held[0]) return DIR_UP;
        else if (held[1]) return DIR_RIGHT;
        else if (held[2]) return DIR_DOWN;
        else if (held[3]) return DIR_LEFT;
        else              return DIR_NONE;
    endfunction

    function automatic logic [3:0] code_to_onehot(input logic [2:0] code);
        case (code)
            DIR_UP:    return 4'b0001;
            DIR_RIGHT: return 4'b0010;
            DIR_DOWN:  return 4'b0100;
            DIR_LEFT:  return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_direction_encoder_dir_arbiter.sv
// Per-player held-key tracking and direction resolution with registered
// direction outputs.
module dir_arbiter
    import ps2_direction_encoder_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       make_valid,
    input  logic       break_valid,
    input  logic [1:0] key_idx,
    output logic [2:0] dir_code,
    output logic [3:0] dir_onehot
);

    logic [3:0] held, held_next;
    logic [1:0] last, last_next;
    logic [2:0] dir_next;

    always_comb begin
        held_next = held;
        last_next = last;
        if (make_valid) begin
            held_next[key_idx] = 1'b1;
            last_next          = key_idx;
        end else if (break_valid) begin
            held_next[key_idx] = 1'b0;
        end
        dir_next = resolve_dir(held_next, last_next);
    end

    // Outputs are registered from next-state values so they settle one edge after the strobe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            held       <= 4'b0000;
            last       <= 2'd0;
            dir_code   <= DIR_NONE;
            dir_onehot <= 4'b0000;
        end else begin
            held       <= held_next;
            last       <= last_next;
            dir_code   <= dir_next;
            dir_onehot <= code_to_onehot(dir_next);
        end
    end

endmodule

// File: rtl/ps2_direction_encoder.sv
// PS/2 scancode parser feeding two independent direction arbiters plus a
// pause-key edge detector.
module ps2_direction_encoder
    import ps2_direction_encoder_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_out,
    output logic       upSig,
    output logic       rightSig,
    output logic       downSig,
    output logic       leftSig,
    output logic       upSig2,
    output logic       rightSig2,
    output logic       downSig2,
    output logic       leftSig2,
    output logic [2:0] dir_code0,
    output logic [2:0] dir_code1,
    output logic       pauseButton
);

    localparam int CNT_W = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(PREFIX_TIMEOUT);

    parse_state_t   state, state_next;
    logic [CNT_W-1:0] idle_cnt;
    logic           timeout;
    key_hit_t       hit0, hit1;
    logic           make0, break0, make1, break1;
    logic           p_make, p_break, p_held;
    logic [3:0]     onehot0, onehot1;

    assign hit0 = lookup_p0(ps2_out);
    assign hit1 = lookup_p1(ps2_out);

    // Idle cycles are counted only while a prefix is pending.
    assign timeout = !ps2_key_pressed && (state != IDLE) &&
                     ((idle_cnt + CNT_W'(1)) == TIMEOUT_LIMIT);

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            idle_cnt <= '0;
        else if (ps2_key_pressed || (state == IDLE) || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + CNT_W'(1);
    end

    always_comb begin
        state_next = state;
        make0      = 1'b0;
        break0     = 1'b0;
        make1      = 1'b0;
        break1     = 1'b0;
        p_make     = 1'b0;
        p_break    = 1'b0;
        if (ps2_key_pressed) begin
            if (ps2_out == SC_E1) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ps2_out == SC_E0)      state_next = EXT;
                        else if (ps2_out == SC_F0) state_next = BRK;
                        else begin
                            make0  = hit0.hit;
                            p_make = (ps2_out == KEY_P);
                        end
                    end
                    EXT: begin
                        if (ps2_out == SC_F0) begin
                            state_next = EXT_BRK;
                        end else begin
                            state_next = IDLE;
                            make1      = hit1.hit && (ps2_out != SC_E0);
                        end
                    end
                    BRK: begin
                        state_next = IDLE;
                        break0     = hit0.hit;
                        p_break    = (ps2_out == KEY_P);
                    end
                    EXT_BRK: begin
                        state_next = IDLE;
                        break1     = hit1.hit;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end else if (timeout) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            p_held      <= 1'b0;
            pauseButton <= 1'b0;
        end else begin
            pauseButton <= p_make && !p_held;
            if (p_make)       p_held <= 1'b1;
            else if (p_break) p_held <= 1'b0;
        end
    end

    dir_arbiter u_arb0 (
        .clock       (clock),
        .reset       (reset),
        .make_valid  (make0),
        .break_valid (break0),
        .key_idx     (hit0.idx),
        .dir_code    (dir_code0),
        .dir_onehot  (onehot0)
    );

    dir_arbiter u_arb1 (
        .clock       (clock),
        .reset       (reset),
        .make_valid  (make1),
        .break_valid (break1),
        .key_idx     (hit1.idx),
        .dir_code    (dir_code1),
        .dir_onehot  (onehot1)
    );

    assign upSig     = onehot0[0];
    assign rightSig  = onehot0[1];
    assign downSig   = onehot0[2];
    assign leftSig   = onehot0[3];
    assign upSig2    = onehot1[0];
    assign rightSig2 = onehot1[1];
    assign downSig2  = onehot1[2];
    assign leftSig2  = onehot1[3];

endmodule

// File: tb/tb_ps2_direction_encoder.sv
// Directed and randomized scancode streams checked every cycle against a
// byte-level behavioural model of the key map and hold rules.
module tb_ps2_direction_encoder;

    localparam int TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;
    logic       upSig, rightSig, downSig, leftSig;
    logic       upSig2, rightSig2, downSig2, leftSig2;
    logic [2:0] dir_code0, dir_code1;
    logic       pauseButton;

    always #5 clock = ~clock;

    ps2_direction_encoder #(.PREFIX_TIMEOUT(TIMEOUT)) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_out         (ps2_out),
        .upSig           (upSig),
        .rightSig        (rightSig),
        .downSig         (downSig),
        .leftSig         (leftSig),
        .upSig2          (upSig2),
        .rightSig2       (rightSig2),
        .downSig2        (downSig2),
        .leftSig2        (leftSig2),
        .dir_code0       (dir_code0),
        .dir_code1       (dir_code1),
        .pauseButton     (pauseButton)
    );

    int vectors = 0;
    int miscompares = 0;
    int pulseCount = 0;

    // Reference model: pending-prefix flags, held keys per player, last pressed.
    logic [7:0] keyTab [2][4];
    logic [7:0] pool [14];
    bit  mheld [2][4];
    int  mlast [2];
    bit  mpheld, mpulse, mext, mbrk;
    int  midle;

    function automatic int modelDir(input int p);
        if (mlast[p] >= 0 && mheld[p][mlast[p]]) return mlast[p] + 1;
        for (int i = 0; i < 4; i++) if (mheld[p][i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [7:0] onehotOf(input int c);
        case (c)
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'h04;
            4: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelReset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) mheld[p][i] = 1'b0;
            mlast[p] = -1;
        end
        mpheld = 1'b0; mpulse = 1'b0; mext = 1'b0; mbrk = 1'b0; midle = 0;
    endtask

    task automatic modelComplete(input logic [7:0] b);
        int p;
        p = mext ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            if (keyTab[p][i] == b) begin
                if (!mbrk) begin mheld[p][i] = 1'b1; mlast[p] = i; end
                else mheld[p][i] = 1'b0;
            end
        end
        if (!mext && b == 8'h4D) begin
            if (!mbrk) begin mpulse = !mpheld; mpheld = 1'b1; end
            else mpheld = 1'b0;
        end
        mext = 1'b0; mbrk = 1'b0;
    endtask

    task automatic modelTick(input bit strobe, input logic [7:0] b);
        mpulse = 1'b0;
        if (strobe) begin
            midle = 0;
            if (b == 8'hE1) begin mext = 1'b0; mbrk = 1'b0; end
            else if (b == 8'hE0) begin
                if (!mext && !mbrk) mext = 1'b1;
                else begin mext = 1'b0; mbrk = 1'b0; end
            end
            else if (b == 8'hF0 && !mbrk) mbrk = 1'b1;
            else modelComplete(b);
        end else if (mext || mbrk) begin
            midle++;
            if (midle == TIMEOUT) begin mext = 1'b0; mbrk = 1'b0; midle = 0; end
        end
    endtask

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int e0, e1;
        e0 = modelDir(0);
        e1 = modelDir(1);
        checkValue("dir_code0", {5'b0, dir_code0}, 8'(e0));
        checkValue("onehot0", {4'b0, leftSig, downSig, rightSig, upSig}, onehotOf(e0));
        checkValue("dir_code1", {5'b0, dir_code1}, 8'(e1));
        checkValue("onehot1", {4'b0, leftSig2, downSig2, rightSig2, upSig2}, onehotOf(e1));
        checkValue("pauseButton", {7'b0, pauseButton}, {7'b0, mpulse});
        if (pauseButton === 1'b1) pulseCount++;
    endtask

    task automatic checkDirect(input string tag, input int exp0, input int exp1);
        checkValue({tag, "_code0"}, {5'b0, dir_code0}, 8'(exp0));
        checkValue({tag, "_code1"}, {5'b0, dir_code1}, 8'(exp1));
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        ps2_key_pressed = 1'b1;
        ps2_out = b;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        ps2_out = 8'($urandom);
        modelTick(1'b1, b);
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            modelTick(1'b0, 8'h00);
            checkOutput();
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        @(negedge clock);
        modelReset();
        checkOutput();
        reset = 1'b1;
    endtask

    initial begin
        keyTab[0] = '{8'h1D, 8'h23, 8'h1B, 8'h1C};
        keyTab[1] = '{8'h75, 8'h74, 8'h72, 8'h6B};
        pool = '{8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h1D, 8'h23, 8'h1B, 8'h1C,
                 8'h75, 8'h74, 8'h72, 8'h6B, 8'h4D, 8'h99};
        modelReset();
        reset = 1'b0;
        ps2_key_pressed = 1'b0;
        ps2_out = 8'h00;
        repeat (2) @(negedge clock);
        checkOutput();
        checkDirect("reset", 0, 0);
        reset = 1'b1;

        // Single make / break on player 0
        applyStimulus(8'h1D);                       checkDirect("w_make", 1, 0);
        applyStimulus(8'hF0); applyStimulus(8'h1D); checkDirect("w_break", 0, 0);

        // Last-pressed override and fallback to the still-held key
        applyStimulus(8'h1D);
        applyStimulus(8'h23);                       checkDirect("d_over_w", 2, 0);
        applyStimulus(8'hF0); applyStimulus(8'h23); checkDirect("back_to_w", 1, 0);
        applyStimulus(8'hF0); applyStimulus(8'h1D); checkDirect("all_up", 0, 0);

        // Priority fallback when last-pressed is released
        applyStimulus(8'h1D); applyStimulus(8'h1C); applyStimulus(8'h1B);
        checkDirect("last_down", 3, 0);
        applyStimulus(8'hF0); applyStimulus(8'h1B); checkDirect("prio_up", 1, 0);
        applyStimulus(8'hF0); applyStimulus(8'h1D); checkDirect("only_left", 4, 0);
        applyStimulus(8'hF0); applyStimulus(8'h1C);

        // Both players concurrently
        applyStimulus(8'hE0); applyStimulus(8'h75); applyStimulus(8'h1C);
        checkDirect("two_players", 4, 1);
        checkValue("up2_left_pair", {6'b0, upSig2, leftSig}, 8'h03);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        checkDirect("both_released", 0, 0);

        // Codes that must be ignored
        applyStimulus(8'h75);                       checkDirect("plain_75", 0, 0);
        applyStimulus(8'hE0); applyStimulus(8'h1D); checkDirect("ext_w", 0, 0);

        // Pause edge detection
        pulseCount = 0;
        applyStimulus(8'h4D); applyStimulus(8'h4D); applyStimulus(8'h4D);
        applyStimulus(8'hF0); applyStimulus(8'h4D); applyStimulus(8'h4D);
        idleCycles(2);
        checkValue("pause_pulses", 8'(pulseCount), 8'd2);
        applyStimulus(8'hF0); applyStimulus(8'h4D);

        // Prefix timeout boundary: one cycle short survives, full timeout discards
        applyStimulus(8'hE0); idleCycles(TIMEOUT - 1); applyStimulus(8'h75);
        checkDirect("no_timeout", 0, 1);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        applyStimulus(8'hE0); idleCycles(TIMEOUT); applyStimulus(8'h75);
        checkDirect("timed_out", 0, 0);
        applyStimulus(8'hE0); applyStimulus(8'h75); checkDirect("after_timeout", 0, 1);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);

        // Reset mid-sequence, stray break, E1 abort
        applyStimulus(8'hE0); doReset(); applyStimulus(8'h72);
        checkDirect("reset_discard", 0, 0);
        applyStimulus(8'hF0); applyStimulus(8'h99); checkDirect("stray_break", 0, 0);
        applyStimulus(8'hE1); applyStimulus(8'h1B); checkDirect("e1_then_s", 3, 0);
        checkValue("downSig", {7'b0, downSig}, 8'h01);
        applyStimulus(8'hF0); applyStimulus(8'h1B);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 3) doReset();
            else if (r < 10) idleCycles($urandom_range(1, TIMEOUT + 4));
            else begin
                b = pool[$urandom_range(0, 13)];
                if (b == 8'h99) b = 8'($urandom);
                applyStimulus(b);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
